// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, types and helpers for the 8-bit datapath
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 1;
  localparam int IMM_W      = 3;
  localparam int NUM_REGS   = 2;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [IMM_W-1:0]      imm_t;

  // Immediates are unsigned: always zero-extend, never sign-extend.
  function automatic data_t imm_extend(input imm_t imm);
    return data_t'(imm);
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - two-entry 8-bit register file, two combinational reads, one write
module register_file
  import cpu_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  reg_addr_t rs,
  input  reg_addr_t rd,
  input  logic      regSelect,
  input  logic      immSelect,
  input  imm_t      imm,
  input  data_t     write_data,
  output data_t     rs_data,
  output data_t     rd_data,
  output data_t     storeData
);

  data_t regs [NUM_REGS];

  data_t w_rs_val;
  data_t w_rd_val;
  data_t w_imm_ext;

  // No forwarding: reads see pre-edge contents of a register being written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs[0] <= '0;
      regs[1] <= '0;
    end else if (regSelect) begin
      regs[rd] <= write_data;
    end
  end

  assign w_rs_val  = regs[rs];
  assign w_rd_val  = regs[rd];
  assign w_imm_ext = imm_extend(imm);

  assign rs_data   = w_rs_val;
  assign rd_data   = immSelect ? w_imm_ext : w_rd_val;
  assign storeData = w_rd_val;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file with a random reference model
module tb_register_file;

  logic       CLK = 1'b0;
  logic       RST;
  logic       rs, rd, regSelect, immSelect;
  logic [2:0] imm;
  logic [7:0] write_data;
  logic [7:0] rs_data, rd_data, storeData;

  register_file dut (
    .CLK        (CLK),
    .RST        (RST),
    .rs         (rs),
    .rd         (rd),
    .regSelect  (regSelect),
    .immSelect  (immSelect),
    .imm        (imm),
    .write_data (write_data),
    .rs_data    (rs_data),
    .rd_data    (rd_data),
    .storeData  (storeData)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [7:0] exp_rs;
    logic [7:0] exp_rd;
    logic [7:0] exp_sd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [2];
  int         checks = 0;
  int         errors = 0;

  task automatic cmp(input string tag, input string port, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %02h expected %02h", tag, port, act, exp);
    end
  endtask

  // Monitor: whenever an expectation is pending, the DUT outputs are settled for it.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      cmp(e.tag, "rs_data",   rs_data,   e.exp_rs);
      cmp(e.tag, "rd_data",   rd_data,   e.exp_rd);
      cmp(e.tag, "storeData", storeData, e.exp_sd);
    end
  end

  // Drive a full input set during the low phase, then queue the expected reads.
  task automatic drive(input string tag, input logic r, input logic a_rs, input logic a_rd,
                       input logic we, input logic isel, input logic [2:0] im, input logic [7:0] wd);
    exp_t e;
    RST = r; rs = a_rs; rd = a_rd; regSelect = we; immSelect = isel; imm = im; write_data = wd;
    if (r) begin
      mdl[0] = 8'h00;
      mdl[1] = 8'h00;
    end
    #1;
    e.tag    = tag;
    e.exp_rs = mdl[a_rs];
    e.exp_rd = isel ? (8'h00 + im) : mdl[a_rd];
    e.exp_sd = mdl[a_rd];
    exp_q.push_back(e);
    #1;
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    if (!RST && regSelect) mdl[rd] = write_data;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; rs = 0; rd = 0; regSelect = 0; immSelect = 0; imm = 0; write_data = 0;
    mdl[0] = 8'h00; mdl[1] = 8'h00;
    @(negedge CLK);

    drive("reset_r0", 1, 0, 0, 1, 0, 3'd0, 8'hEE);
    drive("reset_imm", 1, 1, 1, 1, 1, 3'd6, 8'hEE);
    clk_edge();

    // Load R0=AA, R1=55, then reset asynchronously mid-cycle.
    drive("load_aa", 0, 0, 0, 1, 0, 3'd0, 8'hAA); clk_edge();
    drive("load_55", 0, 1, 1, 1, 0, 3'd0, 8'h55); clk_edge();
    drive("pre_rst", 0, 0, 1, 0, 0, 3'd0, 8'h00);
    drive("midrst_a0", 1, 0, 0, 0, 0, 3'd0, 8'h00); clk_edge();
    drive("midrst_a1", 1, 1, 1, 0, 0, 3'd0, 8'h00); clk_edge();

    drive("wr_r0_3c", 0, 0, 0, 1, 0, 3'd0, 8'h3C); clk_edge();
    drive("rd_r0",    0, 0, 1, 1, 0, 3'd0, 8'hC3); clk_edge();
    drive("rd_r1",    0, 0, 1, 0, 0, 3'd0, 8'hFF); clk_edge();
    drive("wdis_1",   0, 1, 0, 0, 0, 3'd0, 8'hFF); clk_edge();
    drive("wdis_2",   0, 0, 1, 0, 0, 3'd0, 8'hFF); clk_edge();
    drive("imm_5",    0, 0, 1, 0, 1, 3'd5, 8'h00);
    drive("imm_7",    0, 1, 1, 0, 1, 3'd7, 8'h00);
    drive("imm_off",  0, 0, 1, 0, 0, 3'd7, 8'h00); clk_edge();

    drive("rdw_before", 0, 0, 0, 1, 0, 3'd0, 8'h81); clk_edge();
    drive("rdw_after",  0, 0, 0, 0, 0, 3'd0, 8'h00); clk_edge();

    drive("rst_wr",     1, 0, 1, 1, 0, 3'd0, 8'h77); clk_edge();
    drive("rst_wr_chk", 0, 0, 1, 0, 0, 3'd0, 8'h00); clk_edge();

    for (int i = 0; i < 300; i++) begin
      drive("random", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
      clk_edge();
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
